// File: rtl/eth_stats_pkg.sv
// Shared index map and status bit positions for the MAC/PHY statistics collector.
package eth_stats_pkg;

  localparam int IDX_TX_UNDERFLOW       = 0;
  localparam int IDX_RX_BAD_FRAME       = 1;
  localparam int IDX_RX_BAD_FCS         = 2;
  localparam int IDX_RX_BAD_BLOCK       = 3;
  localparam int IDX_RX_FIFO_OVERFLOW   = 4;
  localparam int IDX_RX_FIFO_BAD_FRAME  = 5;
  localparam int IDX_RX_FIFO_GOOD_FRAME = 6;
  localparam int IDX_LOCK_LOSS          = 7;
  localparam int IDX_HIGH_BER_ASSERT    = 8;
  localparam int IDX_STATUS             = 9;
  localparam int NUM_IDX                = 10;

  // Indices 0..8 are real counters; index 9 is the composed status word.
  localparam int NUM_CNT = 9;

  localparam int ST_BLOCK_LOCK = 0;
  localparam int ST_HIGH_BER   = 1;
  localparam int ST_RX_STATUS  = 2;

endpackage

// File: rtl/eth_mac_stats_collector_if.sv
// Register read port of the statistics collector: request in, one-cycle-later response out.
interface eth_mac_stats_collector_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 rd_req;
  logic [3:0]           rd_chan;
  logic [3:0]           rd_idx;
  logic                 rd_clear;
  logic                 rd_valid;
  logic [CNT_WIDTH-1:0] rd_data;
  logic                 rd_err;

  modport master (
    output rd_req, rd_chan, rd_idx, rd_clear,
    input  rd_valid, rd_data, rd_err
  );

  modport slave (
    input  rd_req, rd_chan, rd_idx, rd_clear,
    output rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/eth_stats_counter.sv
// Single statistics counter: saturating or wrapping increment, clear-on-read that keeps
// a coincident event, and a global clear that overrides everything.
module eth_stats_counter #(
  parameter int CNT_WIDTH = 32,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  input  logic                 clr_all,
  output logic [CNT_WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr_all) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_WIDTH'(1) : '0;
    end else if (inc) begin
      if (&count) count <= (SATURATE != 0) ? count : '0;
      else        count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/eth_mac_stats_collector.sv
// Per-channel event counters, lock-loss / high-BER edge counters and sticky status-change
// flags with a maskable interrupt, read through a one-cycle-latency register port.
module eth_mac_stats_collector
  import eth_stats_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int CNT_WIDTH    = 32,
  parameter int SATURATE     = 1,
  parameter int EVENTS       = 7,
  parameter int STATUS_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CHANNELS*EVENTS-1:0]       evt_in,
  input  logic [CHANNELS*STATUS_WIDTH-1:0] status_in,
  input  logic                             clear_all,
  input  logic [CHANNELS*STATUS_WIDTH-1:0] irq_mask,
  eth_mac_stats_collector_if.slave         rd,
  output logic                             irq
);

  logic [CHANNELS*NUM_CNT*CNT_WIDTH-1:0] cnt_flat;
  logic [CHANNELS*STATUS_WIDTH-1:0]      sticky_flat;
  logic [CNT_WIDTH-1:0]                  rd_word;
  logic                                  rd_ok;
  logic                                  rd_clr;

  // Widen rd_chan so the bound check stays meaningful at CHANNELS=16.
  assign rd_ok  = ({1'b0, rd.rd_chan} < 5'(CHANNELS)) && (rd.rd_idx < 4'(NUM_IDX));
  assign rd_clr = rd.rd_req && rd.rd_clear && rd_ok;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [STATUS_WIDTH-1:0] st;
    logic [STATUS_WIDTH-1:0] prev_q;
    logic [STATUS_WIDTH-1:0] sticky_q;
    logic [STATUS_WIDTH-1:0] change;
    logic [NUM_CNT-1:0]      inc;
    logic                    chan_clr;

    assign st       = status_in[c*STATUS_WIDTH +: STATUS_WIDTH];
    assign change   = st ^ prev_q;
    assign chan_clr = rd_clr && (rd.rd_chan == 4'(c));

    assign inc[EVENTS-1:0]          = evt_in[c*EVENTS +: EVENTS];
    assign inc[IDX_LOCK_LOSS]       = prev_q[ST_BLOCK_LOCK] & ~st[ST_BLOCK_LOCK];
    assign inc[IDX_HIGH_BER_ASSERT] = ~prev_q[ST_HIGH_BER] & st[ST_HIGH_BER];

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
      eth_stats_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .SATURATE  (SATURATE)
      ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (inc[i]),
        .clr     (chan_clr && (rd.rd_idx == 4'(i))),
        .clr_all (clear_all),
        .count   (cnt_flat[(c*NUM_CNT+i)*CNT_WIDTH +: CNT_WIDTH])
      );
    end

    // prev keeps tracking through clear_all so no false edge appears afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev_q   <= '0;
        sticky_q <= '0;
      end else begin
        prev_q <= st;
        if (clear_all)
          sticky_q <= '0;
        else if (chan_clr && (rd.rd_idx == 4'(IDX_STATUS)))
          sticky_q <= change;
        else
          sticky_q <= sticky_q | change;
      end
    end

    assign sticky_flat[c*STATUS_WIDTH +: STATUS_WIDTH] = sticky_q;
  end

  // NOTE: default assignment first so this combinational mux never infers a latch.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd.rd_chan == 4'(c)) begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (rd.rd_idx == 4'(i))
            rd_word = cnt_flat[(c*NUM_CNT+i)*CNT_WIDTH +: CNT_WIDTH];
        end
        if (rd.rd_idx == 4'(IDX_STATUS))
          rd_word = CNT_WIDTH'({sticky_flat[c*STATUS_WIDTH +: STATUS_WIDTH], 1'b0,
                                status_in[c*STATUS_WIDTH +: STATUS_WIDTH]});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd.rd_valid <= 1'b0;
      rd.rd_err   <= 1'b0;
      rd.rd_data  <= '0;
      irq         <= 1'b0;
    end else begin
      rd.rd_valid <= rd.rd_req;
      rd.rd_err   <= rd.rd_req && !rd_ok;
      if (rd.rd_req) rd.rd_data <= rd_word;
      irq <= |(sticky_flat & irq_mask);
    end
  end

endmodule

// File: tb/tb_eth_mac_stats_collector.sv
// Bench for the statistics collector: a saturating and a wrapping instance, both checked
// against a spec-level model plus directed vectors for the corner cases.
module tb_eth_mac_stats_collector;
  import eth_stats_pkg::*;

  localparam int CH   = 4;
  localparam int W    = 8;
  localparam int EV   = 7;
  localparam int SW   = 3;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [CH*EV-1:0] evt_in;
  logic [CH*SW-1:0] status_in;
  logic [CH*SW-1:0] irq_mask;
  logic           clear_all;
  logic           rd_req;
  logic           rd_clear;
  logic [3:0]     rd_chan;
  logic [3:0]     rd_idx;
  logic           irq_s;
  logic           irq_w;

  eth_mac_stats_collector_if #(.CNT_WIDTH(W)) bus_s ();
  eth_mac_stats_collector_if #(.CNT_WIDTH(W)) bus_w ();

  assign bus_s.rd_req   = rd_req;
  assign bus_s.rd_chan  = rd_chan;
  assign bus_s.rd_idx   = rd_idx;
  assign bus_s.rd_clear = rd_clear;
  assign bus_w.rd_req   = rd_req;
  assign bus_w.rd_chan  = rd_chan;
  assign bus_w.rd_idx   = rd_idx;
  assign bus_w.rd_clear = rd_clear;

  eth_mac_stats_collector #(
    .CHANNELS(CH), .CNT_WIDTH(W), .SATURATE(1), .EVENTS(EV), .STATUS_WIDTH(SW)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .evt_in(evt_in), .status_in(status_in),
    .clear_all(clear_all), .irq_mask(irq_mask), .rd(bus_s.slave), .irq(irq_s)
  );

  eth_mac_stats_collector #(
    .CHANNELS(CH), .CNT_WIDTH(W), .SATURATE(0), .EVENTS(EV), .STATUS_WIDTH(SW)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .evt_in(evt_in), .status_in(status_in),
    .clear_all(clear_all), .irq_mask(irq_mask), .rd(bus_w.slave), .irq(irq_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Reference state: [0] saturating instance, [1] wrapping instance.
  int unsigned    m_cnt [2][CH][NUM_CNT];
  logic [SW-1:0]  m_prev [CH];
  logic [SW-1:0]  m_sticky [CH];
  logic [W-1:0]   m_data [2];
  logic           m_valid, m_err, m_irq;

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_data[v] = '0;
      for (int c = 0; c < CH; c++)
        for (int i = 0; i < NUM_CNT; i++) m_cnt[v][c][i] = 0;
    end
    for (int c = 0; c < CH; c++) begin
      m_prev[c]   = '0;
      m_sticky[c] = '0;
    end
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_irq   = 1'b0;
  endtask

  // Apply current inputs for one clock, advance the model, compare outputs after the edge.
  task automatic step();
    bit            ok, hit;
    bit            e [NUM_CNT];
    logic [SW-1:0] st, chg;
    int unsigned   nxt;
    int            rc, ri;
    rc = int'(rd_chan);
    ri = int'(rd_idx);
    ok = (rc < CH) && (ri < NUM_IDX);
    m_valid = rd_req;
    m_err   = rd_req && !ok;
    if (rd_req) begin
      for (int v = 0; v < 2; v++) begin
        if (!ok)                 m_data[v] = '0;
        else if (ri == IDX_STATUS) m_data[v] = W'({m_sticky[rc], 1'b0, status_in[rc*SW +: SW]});
        else                     m_data[v] = W'(m_cnt[v][rc][ri]);
      end
    end
    m_irq = 1'b0;
    for (int c = 0; c < CH; c++)
      if (|(m_sticky[c] & irq_mask[c*SW +: SW])) m_irq = 1'b1;

    for (int c = 0; c < CH; c++) begin
      st  = status_in[c*SW +: SW];
      chg = st ^ m_prev[c];
      for (int i = 0; i < EV; i++) e[i] = evt_in[c*EV+i];
      e[IDX_LOCK_LOSS]       = m_prev[c][ST_BLOCK_LOCK] && !st[ST_BLOCK_LOCK];
      e[IDX_HIGH_BER_ASSERT] = !m_prev[c][ST_HIGH_BER] && st[ST_HIGH_BER];
      for (int i = 0; i < NUM_CNT; i++) begin
        hit = rd_req && rd_clear && ok && (rc == c) && (ri == i);
        for (int v = 0; v < 2; v++) begin
          nxt = m_cnt[v][c][i] + 1;
          if (clear_all)  m_cnt[v][c][i] = 0;
          else if (hit)   m_cnt[v][c][i] = e[i] ? 1 : 0;
          else if (e[i])  m_cnt[v][c][i] = (v == 0) ? ((nxt > MAXV) ? MAXV : nxt) : (nxt % (MAXV + 1));
        end
      end
      hit = rd_req && rd_clear && ok && (rc == c) && (ri == IDX_STATUS);
      if (clear_all) m_sticky[c] = '0;
      else if (hit)  m_sticky[c] = chg;
      else           m_sticky[c] = m_sticky[c] | chg;
      m_prev[c] = st;
    end

    @(posedge clk);
    #1;
    check("rd_valid_sat", bus_s.rd_valid, m_valid);
    check("rd_err_sat",   bus_s.rd_err,   m_err);
    check("rd_data_sat",  bus_s.rd_data,  m_data[0]);
    check("irq_sat",      irq_s,          m_irq);
    check("rd_valid_wrap", bus_w.rd_valid, m_valid);
    check("rd_err_wrap",   bus_w.rd_err,   m_err);
    check("rd_data_wrap",  bus_w.rd_data,  m_data[1]);
    check("irq_wrap",      irq_w,          m_irq);
  endtask

  task automatic read(input int c, input int i, input bit clr);
    rd_req   = 1'b1;
    rd_chan  = 4'(c);
    rd_idx   = 4'(i);
    rd_clear = clr;
    step();
    rd_req   = 1'b0;
    rd_clear = 1'b0;
  endtask

  task automatic pulse(input int bitpos, input int n);
    for (int k = 0; k < n; k++) begin
      evt_in = '0;
      evt_in[bitpos] = 1'b1;
      step();
    end
    evt_in = '0;
  endtask

  typedef struct {
    int         chan;
    int         idx;
    bit         clr;
    logic [W-1:0] exp_data;
    bit         exp_err;
  } rd_vec_t;

  rd_vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pos;
    tbl[0] = '{chan: 2, idx: IDX_RX_BAD_FCS,   clr: 0, exp_data: 8'd5, exp_err: 0};
    tbl[1] = '{chan: 1, idx: IDX_RX_BAD_FCS,   clr: 0, exp_data: 8'd0, exp_err: 0};
    tbl[2] = '{chan: 1, idx: IDX_RX_BAD_FRAME, clr: 0, exp_data: 8'd3, exp_err: 0};
    tbl[3] = '{chan: CH, idx: 0,               clr: 0, exp_data: 8'd0, exp_err: 1};
    tbl[4] = '{chan: 0, idx: 12,               clr: 0, exp_data: 8'd0, exp_err: 1};
    tbl[5] = '{chan: 2, idx: 12,               clr: 1, exp_data: 8'd0, exp_err: 1};
    tbl[6] = '{chan: CH, idx: IDX_RX_BAD_FCS,  clr: 1, exp_data: 8'd0, exp_err: 1};
    tbl[7] = '{chan: 2, idx: IDX_RX_BAD_FCS,   clr: 0, exp_data: 8'd5, exp_err: 0};

    rst_n = 1'b0; evt_in = '0; status_in = '0; irq_mask = '0; clear_all = 1'b0;
    rd_req = 1'b0; rd_clear = 1'b0; rd_chan = '0; rd_idx = '0;
    model_reset();
    #22;
    check("reset_rd_valid", bus_s.rd_valid, 1'b0);
    check("reset_rd_data",  bus_s.rd_data,  '0);
    check("reset_rd_err",   bus_s.rd_err,   1'b0);
    check("reset_irq",      irq_s,          1'b0);
    rst_n = 1'b1;

    // Basic counting and the read-port vectors.
    pulse(2*EV + IDX_RX_BAD_FCS, 5);
    pulse(1*EV + IDX_RX_BAD_FRAME, 3);
    for (int k = 0; k < 8; k++) begin
      read(tbl[k].chan, tbl[k].idx, tbl[k].clr);
      check("tbl_valid", bus_s.rd_valid, 1'b1);
      check("tbl_data",  bus_s.rd_data,  tbl[k].exp_data);
      check("tbl_err",   bus_s.rd_err,   tbl[k].exp_err);
    end

    // 300 events on two counters at once: saturating holds at 255, wrapping lands on 44.
    for (int k = 0; k < 300; k++) begin
      evt_in = '0;
      evt_in[1*EV + IDX_TX_UNDERFLOW] = 1'b1;
      evt_in[0*EV + IDX_RX_BAD_BLOCK] = 1'b1;
      step();
    end
    evt_in = '0;
    read(1, IDX_TX_UNDERFLOW, 0);
    check("sat_ch1_idx0",  bus_s.rd_data, 8'd255);
    check("wrap_ch1_idx0", bus_w.rd_data, 8'd44);
    read(0, IDX_RX_BAD_BLOCK, 0);
    check("sat_ch0_idx3",  bus_s.rd_data, 8'd255);
    check("wrap_ch0_idx3", bus_w.rd_data, 8'd44);

    // Clear-on-read racing a good_frame event keeps the event.
    pulse(0*EV + IDX_RX_FIFO_GOOD_FRAME, 10);
    evt_in[0*EV + IDX_RX_FIFO_GOOD_FRAME] = 1'b1;
    read(0, IDX_RX_FIFO_GOOD_FRAME, 1);
    evt_in = '0;
    check("cor_old_value", bus_s.rd_data, 8'd10);
    read(0, IDX_RX_FIFO_GOOD_FRAME, 0);
    check("cor_kept_event", bus_s.rd_data, 8'd1);

    // ch3 block_lock 1 -> 0 -> 1 with its mask bit set.
    irq_mask = '0;
    irq_mask[3*SW + ST_BLOCK_LOCK] = 1'b1;
    status_in[3*SW + ST_BLOCK_LOCK] = 1'b1; step();
    status_in[3*SW + ST_BLOCK_LOCK] = 1'b0; step();
    status_in[3*SW + ST_BLOCK_LOCK] = 1'b1; step();
    step(); step();
    read(3, IDX_LOCK_LOSS, 0);
    check("lock_loss_once", bus_s.rd_data, 8'd1);
    read(3, IDX_STATUS, 0);
    check("status_word", bus_s.rd_data, 8'h11);
    check("irq_set", irq_s, 1'b1);
    read(3, IDX_STATUS, 1);
    check("irq_hold_after_cor", irq_s, 1'b1);
    step();
    check("irq_clear_after_cor", irq_s, 1'b0);
    read(3, IDX_STATUS, 0);
    check("status_after_cor", bus_s.rd_data, 8'h01);

    // clear_all with every event firing and a read in the same cycle.
    evt_in = '1;
    clear_all = 1'b1;
    read(2, IDX_RX_BAD_FCS, 0);
    check("read_preclear", bus_s.rd_data, 8'd5);
    evt_in = '0;
    clear_all = 1'b0;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < NUM_CNT; i++) begin
        read(c, i, 0);
        check("after_clear_all", bus_s.rd_data, 8'd0);
      end
    check("irq_after_clear_all", irq_s, 1'b0);

    // Randomised traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      if (k % 100 == 0) irq_mask = CH*SW'($urandom);
      evt_in    = CH*EV'($urandom & $urandom & $urandom);
      clear_all = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) begin
        pos = $urandom_range(0, CH*SW-1);
        status_in[pos] = ~status_in[pos];
      end
      rd_req   = $urandom_range(0, 1) == 1;
      rd_chan  = 4'($urandom_range(0, CH+1));
      rd_idx   = 4'($urandom_range(0, 11));
      rd_clear = ($urandom_range(0, 3) == 0);
      step();
    end
    evt_in = '0; clear_all = 1'b0; rd_req = 1'b0; rd_clear = 1'b0;

    // Reset in the middle of activity: outputs drop without a clock edge.
    irq_mask = '1;
    status_in[0*SW + ST_BLOCK_LOCK] = ~status_in[0*SW + ST_BLOCK_LOCK];
    pulse(0*EV + IDX_RX_FIFO_GOOD_FRAME, 3);
    read(0, IDX_RX_FIFO_GOOD_FRAME, 0);
    check("pre_reset_valid", bus_s.rd_valid, 1'b1);
    check("pre_reset_irq",   irq_s,          1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus_s.rd_valid, 1'b0);
    check("async_rst_data",  bus_s.rd_data,  '0);
    check("async_rst_err",   bus_s.rd_err,   1'b0);
    check("async_rst_irq",   irq_s,          1'b0);
    check("async_rst_irq_wrap", irq_w,       1'b0);
    status_in = '0;
    model_reset();
    #10;
    rst_n = 1'b1;
    read(0, IDX_RX_FIFO_GOOD_FRAME, 0);
    check("post_reset_cnt", bus_s.rd_data, 8'd0);
    read(3, IDX_LOCK_LOSS, 0);
    check("post_reset_lock", bus_s.rd_data, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
